// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//
// Purpose:
//   Round-robin scheduler sharing one fixed-latency CORDIC magnitude/angle
//   pipeline between N_REQ gradient requesters. One (dx, dy) pair is issued
//   per cycle from the winning requester. The requester ID travels alongside
//   the core through a CORE_LAT-deep tag pipeline so that every result can be
//   routed back to its originator. Per-requester credit counters cap the
//   number of in-flight operations. A level-sensitive flush stops new issues
//   and drains the pipeline.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is combinational)
//   req_x, req_y          packed operands, requester i at [i*DW +: DW]
//   core_x/y/z, core_valid           registered issue to the core (z is always 0)
//   core_out_x/z, core_out_valid     result from the core
//   res_valid             registered one-hot result strobe
//   res_mag, res_ang      registered result, shared by all requesters
//   flush, flush_done     drain request / one-cycle drain-complete pulse
//   busy                  registered: something in flight or state not IDLE
//   tag_err               sticky tag-pipeline / credit-underflow error
//   dbg_state             current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshake: a requester transfers one operand pair in every cycle where its
// req_valid and req_ready bits are both high at the rising clock edge. At most
// one req_ready bit is high per cycle, and req_ready is never high without
// the matching req_valid. Results carry no backpressure.
// -----------------------------------------------------------------------------
module cordic_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 16,
    parameter int NORM     = 20,
    parameter int CORE_LAT = 15,
    parameter int MAX_OUT  = 8,
    parameter int CW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*DW-1:0]   req_x,
    input  logic [N_REQ*DW-1:0]   req_y,
    output logic [DW-1:0]         core_x,
    output logic [DW-1:0]         core_y,
    output logic [NORM-1:0]       core_z,
    output logic                  core_valid,
    input  logic [NORM-1:0]       core_out_x,
    input  logic [NORM-1:0]       core_out_z,
    input  logic                  core_out_valid,
    output logic [N_REQ-1:0]      res_valid,
    output logic [NORM-1:0]       res_mag,
    output logic [NORM-1:0]       res_ang,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy,
    output logic                  tag_err,
    output logic [1:0]            dbg_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state;
    // Set once a drain completes while flush is still held, so a long flush
    // does not re-enter DRAIN and pulse flush_done repeatedly.
    logic                drained;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       credit [N_REQ];

    logic [DW-1:0]       slot_x [N_REQ];
    logic [DW-1:0]       slot_y [N_REQ];
    logic [N_REQ-1:0]    eligible;
    logic                grant_any;
    logic [IW-1:0]       grant_id;
    logic [N_REQ-1:0]    grant_vec;
    int                  scan;

    // ID of the operand currently presented on core_x/core_y.
    logic [IW-1:0]       core_id;

    // tag_v[k]/tag_id[k] is stage k+1 of the tag pipeline; stage CORE_LAT
    // lines up with core_out_valid.
    logic [CORE_LAT-1:0] tag_v;
    logic [IW-1:0]       tag_id [CORE_LAT];
    logic                tag_out_v;
    logic [IW-1:0]       tag_out_id;
    logic                pipe_empty;
    logic [N_REQ-1:0]    underflow_vec;

    // ------------------------------------------------------------------
    // Operand unpacking and eligibility
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slot_x[i]   = req_x[i*DW +: DW];
            slot_y[i]   = req_y[i*DW +: DW];
            eligible[i] = req_valid[i]
                          && (credit[i] < CW'(MAX_OUT))
                          && !flush
                          && (state != S_DRAIN);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible requester at or after rr_ptr.
    // The wrap is done by subtraction so non-power-of-two N_REQ works.
    // ------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            if (!grant_any && eligible[scan[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan[IW-1:0];
            end
        end
    end

    // Eligibility already includes req_valid, so a grant is a handshake.
    assign grant_vec  = grant_any ? (N_REQ'(1) << grant_id) : '0;
    assign req_ready  = grant_vec;

    assign pipe_empty = !core_valid && (tag_v == '0);
    assign tag_out_v  = tag_v[CORE_LAT-1];
    assign tag_out_id = tag_id[CORE_LAT-1];

    // Drain completes in the same cycle the FSM leaves DRAIN.
    assign flush_done = (state == S_DRAIN) && pipe_empty;

    assign core_z     = '0;
    assign dbg_state  = state;

    // A result strobe for a requester with no credit and no concurrent
    // handshake means the bookkeeping has gone wrong.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            underflow_vec[i] = res_valid[i] && !grant_vec[i] && (credit[i] == '0);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, round-robin pointer and busy flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            drained <= 1'b0;
            rr_ptr  <= '0;
            busy    <= 1'b0;
        end else begin
            busy <= (state != S_IDLE) || !pipe_empty;

            if (grant_any) begin
                rr_ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + IW'(1);
            end

            if (!flush) begin
                drained <= 1'b0;
            end else if ((state == S_DRAIN) && pipe_empty) begin
                drained <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (flush && !drained) begin
                        state <= S_DRAIN;
                    end else if (!flush && (req_valid != '0)) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_DRAIN;
                    end else if ((req_valid == '0) && pipe_empty) begin
                        state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue register, tag pipeline, result return, credits, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_x     <= '0;
            core_y     <= '0;
            core_valid <= 1'b0;
            core_id    <= '0;
            tag_v      <= '0;
            for (int k = 0; k < CORE_LAT; k++) begin
                tag_id[k] <= '0;
            end
            res_valid  <= '0;
            res_mag    <= '0;
            res_ang    <= '0;
            tag_err    <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                credit[i] <= '0;
            end
        end else begin
            // Issue: operands hold their last values while no grant occurs.
            core_valid <= grant_any;
            if (grant_any) begin
                core_x  <= slot_x[grant_id];
                core_y  <= slot_y[grant_id];
                core_id <= grant_id;
            end

            // Tag pipeline runs in lock-step with the core input.
            tag_v     <= {tag_v[CORE_LAT-2:0], core_valid};
            tag_id[0] <= core_id;
            for (int k = 1; k < CORE_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end

            // Return path is driven by the tag, not by core_out_valid, so a
            // misbehaving core cannot steer a result to the wrong requester.
            res_valid <= tag_out_v ? (N_REQ'(1) << tag_out_id) : '0;
            if (tag_out_v) begin
                res_mag <= core_out_x;
                res_ang <= core_out_z;
            end

            // Credits: simultaneous grant and result leave the count unchanged.
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_vec[i] && !res_valid[i]) begin
                    credit[i] <= credit[i] + CW'(1);
                end else if (!grant_vec[i] && res_valid[i] && (credit[i] != '0)) begin
                    credit[i] <= credit[i] - CW'(1);
                end
            end

            if ((tag_out_v != core_out_valid) || (underflow_vec != '0)) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_arbiter
//
// Bench for cordic_arbiter with a stub core: a delay line whose latency is
// CORE_LAT (or CORE_LAT+1 when core_extra is set) and whose outputs are simple
// arithmetic functions of the operands. A negedge monitor pushes the expected
// result of every handshake into exp_q and pops it when res_valid fires.
// -----------------------------------------------------------------------------
module tb_cordic_arbiter;

    localparam int N_REQ    = 4;
    localparam int DW       = 16;
    localparam int NORM     = 20;
    localparam int CORE_LAT = 15;
    localparam int MAX_OUT  = 8;
    localparam int CW       = 4;
    localparam int IW       = 2;
    localparam int LAT      = CORE_LAT + 2;
    localparam int W        = IW + 2 * NORM;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_x;
    logic [N_REQ*DW-1:0] req_y;
    logic [DW-1:0]       core_x;
    logic [DW-1:0]       core_y;
    logic [NORM-1:0]     core_z;
    logic                core_valid;
    logic [NORM-1:0]     core_out_x;
    logic [NORM-1:0]     core_out_z;
    logic                core_out_valid;
    logic [N_REQ-1:0]    res_valid;
    logic [NORM-1:0]     res_mag;
    logic [NORM-1:0]     res_ang;
    logic                flush;
    logic                flush_done;
    logic                busy;
    logic                tag_err;
    logic [1:0]          dbg_state;

    cordic_arbiter #(
        .N_REQ(N_REQ), .DW(DW), .NORM(NORM),
        .CORE_LAT(CORE_LAT), .MAX_OUT(MAX_OUT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .core_x(core_x), .core_y(core_y), .core_z(core_z), .core_valid(core_valid),
        .core_out_x(core_out_x), .core_out_z(core_out_z), .core_out_valid(core_out_valid),
        .res_valid(res_valid), .res_mag(res_mag), .res_ang(res_ang),
        .flush(flush), .flush_done(flush_done), .busy(busy), .tag_err(tag_err),
        .dbg_state(dbg_state)
    );

    // ---------------- stub core ----------------
    function automatic logic [NORM-1:0] mag_f(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return (NORM'(x) * NORM'(3)) ^ NORM'(y);
    endfunction

    function automatic logic [NORM-1:0] ang_f(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return NORM'(x) - (NORM'(y) << 2);
    endfunction

    logic [DW-1:0]   sx [0:CORE_LAT];
    logic [DW-1:0]   sy [0:CORE_LAT];
    logic [CORE_LAT:0] sv;
    int core_extra = 0;
    int tap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sv <= '0;
            for (int k = 0; k <= CORE_LAT; k++) begin
                sx[k] <= '0;
                sy[k] <= '0;
            end
        end else begin
            sv    <= {sv[CORE_LAT-1:0], core_valid};
            sx[0] <= core_x;
            sy[0] <= core_y;
            for (int k = 1; k <= CORE_LAT; k++) begin
                sx[k] <= sx[k-1];
                sy[k] <= sy[k-1];
            end
        end
    end

    always_comb begin
        tap            = CORE_LAT - 1 + core_extra;
        core_out_valid = sv[tap];
        core_out_x     = mag_f(sx[tap], sy[tap]);
        core_out_z     = ang_f(sx[tap], sy[tap]);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b1;
    logic [W-1:0] exp_q[$];
    int           t_q[$];
    logic [W-1:0] e;
    int           t;
    logic [N_REQ-1:0] hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en && rst) begin
            chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
            chk("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
            if (res_valid != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: res_valid=%b with nothing outstanding (t=%0t)",
                             res_valid, $time);
                end else begin
                    e = exp_q.pop_front();
                    t = t_q.pop_front();
                    chk("res_onehot", 64'(res_valid), 64'(N_REQ'(1) << e[W-1 -: IW]));
                    chk("res_mag", 64'(res_mag), 64'(e[2*NORM-1:NORM]));
                    chk("res_ang", 64'(res_ang), 64'(e[NORM-1:0]));
                    chk("res_latency", 64'(cyc - t), 64'(LAT));
                end
            end
            hs = req_valid & req_ready;
            for (int i = 0; i < N_REQ; i++) begin
                if (hs[i]) begin
                    exp_q.push_back({IW'(i), mag_f(req_x[i*DW +: DW], req_y[i*DW +: DW]),
                                     ang_f(req_x[i*DW +: DW], req_y[i*DW +: DW])});
                    t_q.push_back(cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        flush     = 1'b0;
        exp_q.delete();
        t_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < N_REQ; i++) begin
            req_x[i*DW +: DW] = DW'($urandom_range(0, 65535));
            req_y[i*DW +: DW] = DW'($urandom_range(0, 65535));
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drain_in_time"}, 64'(n < 100), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_state_idle"}, 64'(dbg_state), 64'd0);
    endtask

    typedef struct {
        logic [N_REQ-1:0] valid;
        logic [N_REQ-1:0] ready;
    } vec_t;
    vec_t tbl[12];

    // ---------------- test sequence ----------------
    initial begin
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        flush     = 1'b0;

        // Round-robin vectors starting from rr_ptr = 0 with all credits free.
        tbl[0]  = '{4'b0100, 4'b0100};
        tbl[1]  = '{4'b1111, 4'b1000};
        tbl[2]  = '{4'b1111, 4'b0001};
        tbl[3]  = '{4'b0101, 4'b0100};
        tbl[4]  = '{4'b0011, 4'b0001};
        tbl[5]  = '{4'b0000, 4'b0000};
        tbl[6]  = '{4'b1001, 4'b1000};
        tbl[7]  = '{4'b0110, 4'b0010};
        tbl[8]  = '{4'b0010, 4'b0010};
        tbl[9]  = '{4'b1100, 4'b0100};
        tbl[10] = '{4'b0111, 4'b0001};
        tbl[11] = '{4'b1111, 4'b0010};

        // Reset state
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_core_valid", 64'(core_valid), 64'd0);
        chk("rst_core_x", 64'(core_x), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tag_err", 64'(tag_err), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single request from requester 2
        @(posedge clk);
        #1;
        req_x[2*DW +: DW] = DW'(3 << 12);
        req_y[2*DW +: DW] = DW'(4 << 12);
        req_valid = 4'b0100;
        #1 chk("t1_ready", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1 req_valid = '0;
        #1 chk("t1_core_valid", 64'(core_valid), 64'd1);
        chk("t1_core_x", 64'(core_x), 64'(3 << 12));
        chk("t1_core_y", 64'(core_y), 64'(4 << 12));
        wait_drain("t1");
        chk("t1_busy", 64'(busy), 64'd0);

        // Table-driven round-robin vectors
        do_reset();
        for (int v = 0; v < 12; v++) begin
            @(posedge clk);
            #1;
            rand_operands();
            req_valid = tbl[v].valid;
            #1 chk($sformatf("tbl_ready_%0d", v), 64'(req_ready), 64'(tbl[v].ready));
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_drain("tbl");

        // All four requesters valid for 40 cycles: strict rotation, no gaps
        do_reset();
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            rand_operands();
            req_valid = 4'b1111;
            #1 chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_drain("rr");

        // Credit limit: requester 0 alone
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            rand_operands();
            req_valid = 4'b0001;
            #1 chk($sformatf("credit_ready_%0d", k), 64'(req_ready),
                   64'((k < MAX_OUT || k >= LAT + 1) ? 1 : 0));
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_drain("credit");

        // Flush at cycle 5 of continuous traffic; held past the drain
        do_reset();
        for (int k = 0; k < 31; k++) begin
            @(posedge clk);
            #1;
            rand_operands();
            if (k == 5) flush = 1'b1;
            if (k == 30) begin
                flush     = 1'b0;
                req_valid = '0;
            end else begin
                req_valid = 4'b1111;
            end
            #1;
            if (k < 30) begin
                chk($sformatf("flush_ready_%0d", k), 64'(req_ready),
                    64'((k < 5) ? (4'b0001 << (k % 4)) : 0));
                chk($sformatf("flush_done_%0d", k), 64'(flush_done),
                    64'((k == 4 + LAT) ? 1 : 0));
            end
            if (k == 4 + LAT) chk("flush_state_drain", 64'(dbg_state), 64'd2);
            if (k == 5 + LAT) begin
                chk("flush_state_idle", 64'(dbg_state), 64'd0);
                chk("flush_busy_hold", 64'(busy), 64'd1);
            end
            if (k == 6 + LAT) chk("flush_busy_fall", 64'(busy), 64'd0);
        end
        wait_drain("flush");

        // Asynchronous reset with 10 tags in flight
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            rand_operands();
            req_valid = 4'b1111;
        end
        @(posedge clk);
        #3;
        req_valid = '0;
        rst       = 1'b0;
        exp_q.delete();
        t_q.delete();
        #1;
        chk("arst_core_valid", 64'(core_valid), 64'd0);
        chk("arst_core_x", 64'(core_x), 64'd0);
        chk("arst_res_valid", 64'(res_valid), 64'd0);
        chk("arst_res_mag", 64'(res_mag), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_state", 64'(dbg_state), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("arst_tag_err_after", 64'(tag_err), 64'd0);
        chk("arst_busy_after", 64'(busy), 64'd0);

        // Core one cycle slower than CORE_LAT
        mon_en     = 1'b0;
        core_extra = 1;
        do_reset();
        @(posedge clk);
        #1 req_valid = 4'b0010;
        #1 chk("lat_ready", 64'(req_ready), 64'b0010);
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk);
            #1 req_valid = '0;
            #1 chk($sformatf("lat_tag_err_%0d", k), 64'(tag_err), 64'((k >= LAT) ? 1 : 0));
        end
        do_reset();
        #1 chk("lat_tag_err_cleared", 64'(tag_err), 64'd0);
        core_extra = 0;
        mon_en     = 1'b1;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin scheduler that shares one `Cordic_core` magnitude/angle pipeline between N_REQ gradient requesters in the SIFT orientation/descriptor stage. It accepts one (dx, dy) pair per cycle from the winning requester, issues it to the core with `in_z` = 0, and tracks the requester ID through a CORE_LAT-deep tag pipeline. It routes each result back to its originator, applies per-requester outstanding-credit limits, and supports a flush/drain sequence.

## Interface
- N_REQ, 4, number of requesters (2..8).
- DW, 16, gradient component width; must match the core.
- NORM, 20, result width; must match the core.
- CORE_LAT, 15, cycles from `core_valid` to `core_out_valid`; must equal the core's latency.
- MAX_OUT, 8, maximum in-flight operations per requester.
- CW, 4, credit counter width; 2^CW > MAX_OUT.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant (combinational); a handshake occurs when valid and ready are both high.
- req_x, req_y  in  N_REQ*DW  packed dx/dy; requester i occupies bits [i*DW +: DW].
- core_x, core_y  out  DW  registered operands to the core.
- core_z  out  NORM  constant 0.
- core_valid  out  1  registered issue strobe.
- core_out_x, core_out_z  in  NORM  magnitude and angle from the core.
- core_out_valid  in  1  core result valid.
- res_valid  out  N_REQ  one-hot result strobe, registered.
- res_mag, res_ang  out  NORM  registered result, shared by all requesters.
- flush  in  1  level-sensitive request to stop issuing and drain.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  high when any tag is in flight or the state is not IDLE.
- tag_err  out  1  sticky; set when `core_out_valid` disagrees with the tag pipeline.

## Operation
- States:
  - IDLE: no tags in flight, no request.
  - RUN: normal arbitration.
  - DRAIN: no grants; waiting for the tag pipeline to empty.
- State transitions:
  - IDLE→RUN when any `req_valid` is high and `flush` is low.
  - RUN→IDLE when no `req_valid` is high and the pipeline is empty.
  - RUN or IDLE→DRAIN when `flush` is high.
  - DRAIN→IDLE when the pipeline is empty, with `flush_done` pulsed in that same cycle.
  - If `flush` is still high in IDLE, the block stays in IDLE with no grants.
  - Grants are also allowed combinationally while in IDLE, so the first request wins in the same cycle it appears.
- Eligibility: requester i is eligible when `req_valid[i]` is high, `credit[i]` < MAX_OUT, `flush` is low, and the state is not DRAIN.
- Grant selection:
  - At most one `req_ready` bit is high per cycle: the first eligible requester at or after `rr_ptr`, wrapping modulo N_REQ.
  - On a handshake with requester g, `rr_ptr` ← (g+1) mod N_REQ; otherwise `rr_ptr` is held.
- Issue:
  - On a handshake, register `core_x`/`core_y` from slot g and set `core_valid` = 1 next cycle; otherwise `core_valid` = 0.
  - `core_x`/`core_y` hold their last values when idle.
- Tag pipeline:
  - A CORE_LAT-stage shift register of {v, id[log2 N_REQ]} is loaded with {core_valid, id} in parallel with the core input.
  - Stage CORE_LAT is compared against `core_out_valid`; a mismatch sets `tag_err` until reset.
- Return:
  - When the tag output valid is high, the next cycle has `res_valid[id]` = 1, `res_mag` = `core_out_x`, `res_ang` = `core_out_z`.
  - Results have no backpressure; requesters must accept `res_valid` unconditionally.
- Credits:
  - `credit[i]` increments on a handshake with i and decrements on `res_valid[i]`.
  - If both happen in the same cycle, the credit is unchanged.
  - Credit never exceeds MAX_OUT and never underflows; an underflow attempt sets `tag_err`.
- Reset values (rst low, asynchronous):
  - All outputs are 0.
  - State IDLE, `rr_ptr` 0, all credits 0, tag pipeline cleared, `tag_err` 0.
  - Reset mid-operation discards all in-flight tags. The core is reset by the same `rst`.

## Timing
- Handshake at cycle t:
  - `core_valid` at t+1.
  - `core_out_valid` at t+1+CORE_LAT.
  - `res_valid` at t+2+CORE_LAT.
  - Total latency is CORE_LAT+2 = 17 cycles at the defaults.
- Throughput is one issue per cycle, aggregated across requesters.
- A requester at MAX_OUT credits is skipped without moving `rr_ptr`; it becomes eligible again the cycle after its credit drops.
- When `flush` rises at cycle f:
  - `req_ready` is 0 from cycle f onward.
  - A handshake completed at f-1 is still issued and drained.
  - `flush_done` pulses CORE_LAT+2 cycles after the last issued handshake, or 1 cycle after f if the pipeline is already empty.
- `busy` is registered and falls the cycle after the state returns to IDLE with an empty pipeline.

## Test plan
- Single request, requester 2 only, dx=3·2^12, dy=4·2^12 → exactly one `req_ready[2]` pulse; `res_valid[2]` 17 cycles later; `res_mag`/`res_ang` equal the core model output; `credit[2]` returns to 0.
- All four requesters held valid for 40 cycles → grant order 0,1,2,3,0,… with no gaps; each `res_valid` order matches the grant order.
- Requester 0 alone with results withheld by a stubbed core, MAX_OUT=8 → exactly 8 grants, then `req_ready[0]` stays 0; the first `res_valid[0]` re-enables the grant the next cycle.
- `flush` asserted at cycle 5 of continuous traffic → no grants from cycle 5; all pending results are delivered; one `flush_done` pulse; `busy` falls; state IDLE.
- Async `rst` pulled low with 10 tags in flight → all outputs 0 immediately; no `res_valid` after release; `tag_err` stays 0 afterward.
- Stub core with CORE_LAT+1 latency → `tag_err` = 1 on the first result and held until reset.
